axi_stream_header_arbiter: RTL and testbench
============================================

Name: axi_stream_header_arbiter

Overview:
- Schedules header insertion for axi_stream_insert_header. Shares its single insert channel among NUM_SRC header requesters using round-robin arbitration.
- Latches the winning header and presents it on valid_insert/data_insert/keep_insert/byte_insert_cnt.
- Holds the grant until the inserter's output stream completes the packet (last beat handshaken), then re-arbitrates.
- Gives exactly one header per output packet and flags malformed keep masks.

Parameters:
- DATA_WD, 32, data width of header and stream.
- DATA_BYTE_WD, DATA_WD/8, bytes per beat.
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD), width of byte_insert_cnt.
- NUM_SRC, 4, number of header requesters (2..16).
- CNT_WD, 16, width of completed-packet counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NUM_SRC  per-source header request.
- req_data  in  NUM_SRC*DATA_WD  header of source i at bits [i*DATA_WD +: DATA_WD].
- req_keep  in  NUM_SRC*DATA_BYTE_WD  keep of source i, same packing.
- req_ready  out  NUM_SRC  one-hot pulse: header of source i consumed.
- valid_insert  out  1  to inserter.
- data_insert  out  DATA_WD  to inserter.
- keep_insert  out  DATA_BYTE_WD  to inserter.
- byte_insert_cnt  out  BYTE_CNT_WD  to inserter.
- ready_insert  in  1  from inserter.
- mon_valid  in  1  inserter valid_out.
- mon_ready  in  1  downstream ready_out.
- mon_last  in  1  inserter last_out.
- grant_id  out  $clog2(NUM_SRC)  currently granted source.
- busy  out  1  high in OFFER/WAIT_EOP.
- err_keep  out  1  one-cycle pulse on rejected request.
- pkt_cnt  out  CNT_WD  completed packets; wraps.

Behaviour:
- Reset (rst_n=0 at a clock edge, any state): state=IDLE, rr pointer=0. All outputs 0: valid_insert, data_insert, keep_insert, byte_insert_cnt, req_ready, grant_id, busy, err_keep, pkt_cnt. An in-flight grant is abandoned without a req_ready pulse.
- States: IDLE, OFFER, DROP, WAIT_EOP.
- IDLE arbitration:
  - Winner g is the first i with req_valid[i]=1, searching from rr pointer upward and wrapping modulo NUM_SRC.
  - No request: remain in IDLE.
  - At the edge, register grant_id=g and latch req_data[g] and req_keep[g].
- Keep legality: keep must be nonzero and low-contiguous, i.e. keep+1 is a power of two (0001, 0011, 0111, 1111 for 4 bytes).
  - Legal: go to OFFER.
  - Illegal: go to DROP.
- OFFER:
  - valid_insert=1; data_insert and keep_insert come from the latched copy.
  - byte_insert_cnt = popcount(keep) mod 2^BYTE_CNT_WD (1111 encodes as 0 = full word).
  - Latency: request sampled in IDLE at edge n gives valid_insert=1 from cycle n+1.
  - Outputs stay stable while ready_insert=0.
  - On valid_insert&ready_insert: req_ready[g]=1 in the same cycle (combinational), then go to WAIT_EOP, valid_insert=0 next cycle, rr pointer = g+1 mod NUM_SRC.
- DROP (one cycle): req_ready[g]=1 and err_keep=1; rr pointer = g+1; go to IDLE. The inserter is not touched.
- WAIT_EOP:
  - On mon_valid&mon_ready&mon_last: pkt_cnt+1 (wraps at 2^CNT_WD), then go to IDLE.
  - A stalled beat (mon_ready=0) with mon_last=1 is not an end of packet.
- mon_* handshakes in IDLE, OFFER or DROP, including one coinciding with the insert handshake, are ignored and not counted.
- busy = state is OFFER or WAIT_EOP.
- req_ready is only ever asserted to grant_id and is at most one-hot.
- Requesters must hold req_valid/data/keep until req_ready. If req_valid drops during OFFER, the latched header is still offered.
- Minimum turnaround: 1 IDLE cycle between an end of packet and the next valid_insert.
- Fairness: with all sources requesting continuously, grants cycle 0,1,..,NUM_SRC-1,0.

Test Plan:
- Single request: req_valid=0001, data AA55AA55, keep 0111, ready_insert=1 → valid_insert one cycle later with byte_insert_cnt=3; req_ready[0] pulses in the same cycle; busy until mon last handshake; pkt_cnt=1.
- Round-robin: req_valid=1111 held, each packet ends 4 beats later → grant_id sequence 0,1,2,3,0; exactly one valid_insert per packet.
- Backpressure: ready_insert=0 for 5 cycles then 1 → valid_insert, data and keep stable all 5 cycles; single req_ready pulse. mon_ready=0 while mon_last=1 → stays in WAIT_EOP until mon_ready=1.
- Keep encoding/error:
  - keep 1111 → byte_insert_cnt=0.
  - keep 0001 (header AA55AA66) → cnt=1.
  - keep 0101 or 0000 → err_keep pulse, req_ready pulse, no valid_insert, pointer advances.
- Stray/simultaneous last: mon last handshake in IDLE and in the insert-handshake cycle → pkt_cnt unchanged; the next last in WAIT_EOP increments it.
- Reset mid-operation: rst_n=0 for 1 cycle during WAIT_EOP → all outputs 0, next arbitration starts at source 0; pkt_cnt 0xFFFF+1 wraps to 0.

Source files
------------

// File: rtl/axi_stream_header_arbiter.sv
// rtl/axi_stream_header_arbiter.sv - round-robin header scheduler for a single insert channel
module axi_stream_header_arbiter #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int NUM_SRC      = 4,
  parameter int CNT_WD       = 16,
  localparam int ID_WD       = $clog2(NUM_SRC)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_SRC-1:0]              req_valid,
  input  logic [NUM_SRC*DATA_WD-1:0]      req_data,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0] req_keep,
  output logic [NUM_SRC-1:0]              req_ready,
  output logic                            valid_insert,
  output logic [DATA_WD-1:0]              data_insert,
  output logic [DATA_BYTE_WD-1:0]         keep_insert,
  output logic [BYTE_CNT_WD-1:0]          byte_insert_cnt,
  input  logic                            ready_insert,
  input  logic                            mon_valid,
  input  logic                            mon_ready,
  input  logic                            mon_last,
  output logic [ID_WD-1:0]                grant_id,
  output logic                            busy,
  output logic                            err_keep,
  output logic [CNT_WD-1:0]               pkt_cnt
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_OFFER    = 2'd1;
  localparam logic [1:0] S_DROP     = 2'd2;
  localparam logic [1:0] S_WAIT_EOP = 2'd3;
  localparam int POP_WD = BYTE_CNT_WD + 1;

  logic [1:0]              state;
  logic [ID_WD-1:0]        rr_ptr;
  logic [ID_WD-1:0]        grant_q;
  logic [ID_WD-1:0]        winner;
  logic [ID_WD-1:0]        next_ptr;
  logic                    found;
  int                      idx;
  logic [DATA_WD-1:0]      hdr_data;
  logic [DATA_BYTE_WD-1:0] hdr_keep;
  logic [DATA_WD-1:0]      win_data;
  logic [DATA_BYTE_WD-1:0] win_keep;
  logic                    win_keep_ok;
  logic [POP_WD-1:0]       pop;
  logic                    insert_hs;
  logic                    eop;

  // First requester at or after the round-robin pointer, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_SRC;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = ID_WD'(idx);
      end
    end
  end

  always_comb begin
    win_data = '0;
    win_keep = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (winner == ID_WD'(i)) begin
        win_data = req_data[i*DATA_WD +: DATA_WD];
        win_keep = req_keep[i*DATA_BYTE_WD +: DATA_BYTE_WD];
      end
    end
  end

  // Legal keep is nonzero and low-contiguous: keep & (keep+1) clears to zero.
  assign win_keep_ok = (win_keep != '0) &&
                       ((win_keep & (win_keep + DATA_BYTE_WD'(1))) == '0);

  always_comb begin
    pop = '0;
    for (int b = 0; b < DATA_BYTE_WD; b++) begin
      pop = pop + POP_WD'(hdr_keep[b]);
    end
  end

  assign next_ptr  = (grant_q == ID_WD'(NUM_SRC - 1)) ? '0 : grant_q + ID_WD'(1);
  assign insert_hs = (state == S_OFFER) && ready_insert;
  assign eop       = (state == S_WAIT_EOP) && mon_valid && mon_ready && mon_last;

  always_comb begin
    req_ready = '0;
    if (insert_hs || (state == S_DROP)) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (grant_q == ID_WD'(i)) begin
          req_ready[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      grant_q  <= '0;
      hdr_data <= '0;
      hdr_keep <= '0;
      pkt_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            grant_q  <= winner;
            hdr_data <= win_data;
            hdr_keep <= win_keep;
            state    <= win_keep_ok ? S_OFFER : S_DROP;
          end
        end
        S_OFFER: begin
          if (ready_insert) begin
            rr_ptr <= next_ptr;
            state  <= S_WAIT_EOP;
          end
        end
        S_DROP: begin
          rr_ptr <= next_ptr;
          state  <= S_IDLE;
        end
        S_WAIT_EOP: begin
          if (eop) begin
            pkt_cnt <= pkt_cnt + CNT_WD'(1);
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign valid_insert    = (state == S_OFFER);
  assign data_insert     = hdr_data;
  assign keep_insert     = hdr_keep;
  assign byte_insert_cnt = pop[BYTE_CNT_WD-1:0];
  assign grant_id        = grant_q;
  assign busy            = (state == S_OFFER) || (state == S_WAIT_EOP);
  assign err_keep        = (state == S_DROP);

endmodule

// File: tb/tb_axi_stream_header_arbiter.sv
// tb/tb_axi_stream_header_arbiter.sv - directed self-checking bench for the header arbiter
module tb_axi_stream_header_arbiter;

  localparam int DW = 32;
  localparam int NB = 4;
  localparam int NS = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NS-1:0]    req_valid;
  logic [NS*DW-1:0] req_data;
  logic [NS*NB-1:0] req_keep;
  logic [NS-1:0]    req_ready;
  logic             valid_insert;
  logic [DW-1:0]    data_insert;
  logic [NB-1:0]    keep_insert;
  logic [1:0]       byte_insert_cnt;
  logic             ready_insert;
  logic             mon_valid, mon_ready, mon_last;
  logic [1:0]       grant_id;
  logic             busy, err_keep;
  logic [15:0]      pkt_cnt;

  logic [NS-1:0]    s_req_ready;
  logic             s_valid_insert;
  logic [DW-1:0]    s_data_insert;
  logic [NB-1:0]    s_keep_insert;
  logic [1:0]       s_byte_insert_cnt;
  logic [1:0]       s_grant_id;
  logic             s_busy, s_err_keep;
  logic [1:0]       s_pkt_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] rr_hdr [NS];

  always #5 clk = ~clk;

  axi_stream_header_arbiter #(.DATA_WD(DW), .NUM_SRC(NS), .CNT_WD(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_keep(req_keep), .req_ready(req_ready), .valid_insert(valid_insert),
    .data_insert(data_insert), .keep_insert(keep_insert),
    .byte_insert_cnt(byte_insert_cnt), .ready_insert(ready_insert),
    .mon_valid(mon_valid), .mon_ready(mon_ready), .mon_last(mon_last),
    .grant_id(grant_id), .busy(busy), .err_keep(err_keep), .pkt_cnt(pkt_cnt)
  );

  // Narrow packet counter copy so counter wrap is reachable in a short run.
  axi_stream_header_arbiter #(.DATA_WD(DW), .NUM_SRC(NS), .CNT_WD(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_keep(req_keep), .req_ready(s_req_ready), .valid_insert(s_valid_insert),
    .data_insert(s_data_insert), .keep_insert(s_keep_insert),
    .byte_insert_cnt(s_byte_insert_cnt), .ready_insert(ready_insert),
    .mon_valid(mon_valid), .mon_ready(mon_ready), .mon_last(mon_last),
    .grant_id(s_grant_id), .busy(s_busy), .err_keep(s_err_keep), .pkt_cnt(s_pkt_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int i, input logic [DW-1:0] d, input logic [NB-1:0] k);
    req_data[i*DW +: DW] = d;
    req_keep[i*NB +: NB] = k;
  endtask

  task automatic set_mon(input logic v, input logic r, input logic l);
    mon_valid = v;
    mon_ready = r;
    mon_last  = l;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 64'(valid_insert), 64'd0);
    chk({tag, "_data"},  64'(data_insert),  64'd0);
    chk({tag, "_keep"},  64'(keep_insert),  64'd0);
    chk({tag, "_cnt"},   64'(byte_insert_cnt), 64'd0);
    chk({tag, "_ready"}, 64'(req_ready),    64'd0);
    chk({tag, "_grant"}, 64'(grant_id),     64'd0);
    chk({tag, "_busy"},  64'(busy),         64'd0);
    chk({tag, "_err"},   64'(err_keep),     64'd0);
    chk({tag, "_pkt"},   64'(pkt_cnt),      64'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_data = '0; req_keep = '0;
    ready_insert = 1'b0; set_mon(1'b0, 1'b0, 1'b0);
    rr_hdr[0] = 32'h1000_0000; rr_hdr[1] = 32'h1111_1111;
    rr_hdr[2] = 32'h2222_2222; rr_hdr[3] = 32'h3333_3333;
    tick(); tick();
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Single request, keep 0111
    set_src(0, 32'hAA55AA55, 4'b0111);
    req_valid = 4'b0001; ready_insert = 1'b1;
    tick();
    chk("t1_valid", 64'(valid_insert), 64'd1);
    chk("t1_data", 64'(data_insert), 64'hAA55AA55);
    chk("t1_keep", 64'(keep_insert), 64'h7);
    chk("t1_cnt", 64'(byte_insert_cnt), 64'd3);
    chk("t1_ready", 64'(req_ready), 64'h1);
    chk("t1_busy", 64'(busy), 64'd1);
    req_valid = '0;
    tick();
    chk("t1_wait_valid", 64'(valid_insert), 64'd0);
    chk("t1_wait_ready", 64'(req_ready), 64'd0);
    chk("t1_wait_busy", 64'(busy), 64'd1);
    set_mon(1'b1, 1'b1, 1'b0);
    tick();
    chk("t1_mid_busy", 64'(busy), 64'd1);
    set_mon(1'b1, 1'b1, 1'b1);
    tick();
    set_mon(1'b0, 1'b0, 1'b0);
    chk("t1_done_busy", 64'(busy), 64'd0);
    chk("t1_pkt", 64'(pkt_cnt), 64'd1);

    // Round-robin from a fresh pointer
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int i = 0; i < NS; i++) set_src(i, rr_hdr[i], 4'b1111);
    req_valid = 4'b1111;
    for (int p = 0; p < 5; p++) begin
      tick();
      chk("rr_grant", 64'(grant_id), 64'(p % NS));
      chk("rr_valid", 64'(valid_insert), 64'd1);
      chk("rr_data", 64'(data_insert), 64'(rr_hdr[p % NS]));
      chk("rr_ready", 64'(req_ready), 64'(4'b0001 << (p % NS)));
      chk("rr_cnt", 64'(byte_insert_cnt), 64'd0);
      tick();
      set_mon(1'b1, 1'b1, 1'b0);
      for (int b = 0; b < 3; b++) begin
        chk("rr_one_valid", 64'(valid_insert), 64'd0);
        tick();
      end
      set_mon(1'b1, 1'b1, 1'b1);
      tick();
      set_mon(1'b0, 1'b0, 1'b0);
      chk("rr_pkt", 64'(pkt_cnt), 64'(p + 1));
      chk("rr_pkt_wrap", 64'(s_pkt_cnt), 64'((p + 1) % 4));
      chk("rr_turnaround", 64'(valid_insert), 64'd0);
    end
    req_valid = '0;

    // Backpressure on source 2 (pointer now 1)
    set_src(2, 32'h1234_5678, 4'b1111);
    req_valid = 4'b0100; ready_insert = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", 64'(valid_insert), 64'd1);
      chk("bp_data", 64'(data_insert), 64'h12345678);
      chk("bp_keep", 64'(keep_insert), 64'hF);
      chk("bp_noready", 64'(req_ready), 64'd0);
      chk("bp_grant", 64'(grant_id), 64'd2);
      if (c < 4) tick();
    end
    ready_insert = 1'b1;
    #1;
    chk("bp_ready", 64'(req_ready), 64'h4);
    tick();
    req_valid = '0;
    chk("bp_after_ready", 64'(req_ready), 64'd0);
    set_mon(1'b1, 1'b0, 1'b1);
    tick(); tick(); tick();
    chk("bp_stall_busy", 64'(busy), 64'd1);
    chk("bp_stall_pkt", 64'(pkt_cnt), 64'd5);
    mon_ready = 1'b1;
    tick();
    set_mon(1'b0, 1'b0, 1'b0);
    chk("bp_eop_busy", 64'(busy), 64'd0);
    chk("bp_eop_pkt", 64'(pkt_cnt), 64'd6);

    // Stray last in IDLE and in the insert-handshake cycle (pointer now 3)
    set_mon(1'b1, 1'b1, 1'b1);
    tick();
    chk("stray_idle_pkt", 64'(pkt_cnt), 64'd6);
    chk("stray_idle_busy", 64'(busy), 64'd0);
    set_src(3, 32'hAA55AA66, 4'b0001);
    req_valid = 4'b1000;
    tick();
    chk("k1_grant", 64'(grant_id), 64'd3);
    chk("k1_data", 64'(data_insert), 64'hAA55AA66);
    chk("k1_cnt", 64'(byte_insert_cnt), 64'd1);
    chk("k1_ready", 64'(req_ready), 64'h8);
    req_valid = '0;
    tick();
    chk("stray_hs_pkt", 64'(pkt_cnt), 64'd6);
    chk("stray_hs_busy", 64'(busy), 64'd1);
    tick();
    set_mon(1'b0, 1'b0, 1'b0);
    chk("stray_next_pkt", 64'(pkt_cnt), 64'd7);

    // Illegal keep 0101 on source 1 (pointer now 0)
    set_src(1, 32'hDEAD_BEEF, 4'b0101);
    req_valid = 4'b0010;
    tick();
    chk("drop1_err", 64'(err_keep), 64'd1);
    chk("drop1_ready", 64'(req_ready), 64'h2);
    chk("drop1_valid", 64'(valid_insert), 64'd0);
    chk("drop1_busy", 64'(busy), 64'd0);
    req_valid = '0;
    tick();
    chk("drop1_err_off", 64'(err_keep), 64'd0);

    // Keep 0000 on source 2 wins over source 0 because the pointer advanced to 2
    set_src(0, 32'h0BAD_CAFE, 4'b0011);
    set_src(2, 32'h5555_5555, 4'b0000);
    req_valid = 4'b0101;
    tick();
    chk("drop0_grant", 64'(grant_id), 64'd2);
    chk("drop0_err", 64'(err_keep), 64'd1);
    chk("drop0_ready", 64'(req_ready), 64'h4);
    req_valid = 4'b0001;
    tick();
    chk("drop0_valid", 64'(valid_insert), 64'd0);
    tick();
    chk("k2_grant", 64'(grant_id), 64'd0);
    chk("k2_valid", 64'(valid_insert), 64'd1);
    chk("k2_cnt", 64'(byte_insert_cnt), 64'd2);
    req_valid = '0;
    tick();
    chk("k2_wait_busy", 64'(busy), 64'd1);

    // Reset mid-packet
    rst_n = 1'b0;
    tick();
    chk_all_zero("midrst");
    chk("midrst_small_pkt", 64'(s_pkt_cnt), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < NS; i++) set_src(i, rr_hdr[i], 4'b1111);
    req_valid = 4'b1110;
    tick();
    chk("midrst_grant", 64'(grant_id), 64'd1);
    req_valid = '0;
    tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    req_valid = 4'b1111;
    tick();
    chk("midrst_ptr0", 64'(grant_id), 64'd0);
    req_valid = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
